// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add dispatch sequencer.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        ISSUE,
        WAIT,
        WB
    } dispatch_state_t;

    localparam logic [31:0] FP_QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] FP_SIGN_MASK = 32'h8000_0000;

endpackage

// File: rtl/fp_op_fifo.sv
// Synchronous FIFO holding decoded FP ops ahead of the adder.
// Push is ignored when full and pop is ignored when empty; pointers wrap modulo DEPTH.
module fp_op_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fp_add_dispatch.sv
// Sequencer in front of the multi-cycle FP adder: buffers ops, launches one at a time,
// detects the adder's done edge (or watchdog expiry) and presents the tagged result.
module fp_add_dispatch
    import fp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             fpu_kick,
    output logic             fpu_valid,
    output logic [31:0]      fpu_op1,
    output logic [31:0]      fpu_op2,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic             timeout_err
);

    localparam int ENT_W = 64 + TAG_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    dispatch_state_t  state_q, state_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             timeout_q, timeout_d;
    logic             done_q;
    logic             completion;

    logic [ENT_W-1:0] push_data;
    logic [ENT_W-1:0] fifo_rdata;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign push_data = {in_op1, (in_sub ? (in_op2 ^ FP_SIGN_MASK) : in_op2), in_tag};

    fp_op_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .wdata_i (push_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign completion  = fpu_done && !done_q;
    assign in_ready    = !fifo_full;
    assign busy        = (fifo_count != '0) || (state_q != IDLE);
    assign fpu_op1     = op1_q;
    assign fpu_op2     = op2_q;
    assign wb_tag      = wb_tag_q;
    assign wb_data     = wb_data_q;
    assign timeout_err = timeout_q;

    // Launch FSM: pop, kick, hold operands, wait for done edge or watchdog, then hand off.
    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        tag_d     = tag_q;
        wd_d      = wd_q;
        wb_tag_d  = wb_tag_q;
        wb_data_d = wb_data_q;
        timeout_d = timeout_q;
        fifo_pop  = 1'b0;
        fpu_kick  = 1'b0;
        fpu_valid = 1'b0;
        wb_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop               = 1'b1;
                    {op1_d, op2_d, tag_d}  = fifo_rdata;
                    state_d                = KICK;
                end
            end
            KICK: begin
                fpu_kick  = 1'b1;
                fpu_valid = 1'b1;
                wd_d      = '0;
                state_d   = ISSUE;
            end
            ISSUE: begin
                fpu_valid = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                fpu_valid = 1'b1;
                if (completion) begin
                    wb_data_d = fpu_result;
                    wb_tag_d  = tag_q;
                    state_d   = WB;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    wb_data_d = FP_QNAN;
                    wb_tag_d  = tag_q;
                    timeout_d = 1'b1;
                    state_d   = WB;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, watchdog and result registers; done_q tracks the adder's done level every
    // cycle so a done left high by the previous op never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            tag_q     <= '0;
            wd_q      <= '0;
            wb_tag_q  <= '0;
            wb_data_q <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            tag_q     <= tag_d;
            wd_q      <= wd_d;
            wb_tag_q  <= wb_tag_d;
            wb_data_q <= wb_data_d;
            timeout_q <= timeout_d;
            done_q    <= fpu_done;
        end
    end

endmodule

// File: tb/tb_fp_add_dispatch.sv
// Self-checking bench for fp_add_dispatch: directed scenarios plus randomized ops, with a
// behavioural adder stand-in and an in-order scoreboard of expected results.
module tb_fp_add_dispatch;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 64;
    localparam int MAXOPS  = 256;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_op1;
    logic [31:0]      in_op2;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             fpu_kick;
    logic             fpu_valid;
    logic [31:0]      fpu_op1;
    logic [31:0]      fpu_op2;
    logic             fpu_done;
    logic [31:0]      fpu_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             busy;
    logic             timeout_err;

    fp_add_dispatch #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .in_sub      (in_sub),
        .in_tag      (in_tag),
        .fpu_kick    (fpu_kick),
        .fpu_valid   (fpu_valid),
        .fpu_op1     (fpu_op1),
        .fpu_op2     (fpu_op2),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Scoreboard: one entry per pushed op, in push order.
    logic [31:0]      expOp1   [MAXOPS];
    logic [31:0]      expOp2   [MAXOPS];
    logic [TAG_W-1:0] expTag   [MAXOPS];
    int               latArr   [MAXOPS];
    int               staleArr [MAXOPS];
    bit               hangArr  [MAXOPS];
    int               kickCycle[MAXOPS];

    int pushIdx     = 0;
    int kickIdx     = 0;
    int wbIdx       = 0;
    int totalChecks = 0;
    int badChecks   = 0;
    int cyc         = 0;
    bit wbRand      = 0;
    bit wbHold      = 1;
    bit prevKick    = 0;
    bit wbSeen      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Stand-in for the external adder: exact sums for the directed pairs, a fixed mix otherwise.
    function automatic logic [31:0] adderModel(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h4040_0000;
            64'h40400000_BF800000: return 32'h4000_0000;
            default:               return a ^ {b[15:0], b[31:16]} ^ 32'h0F0F_1234;
        endcase
    endfunction

    function automatic logic [31:0] expData(input int i);
        return hangArr[i] ? QNAN : adderModel(expOp1[i], expOp2[i]);
    endfunction

    // Kick-to-writeback distance: done edge plus one cycle, or watchdog expiry after TIMEOUT waits.
    function automatic int expLat(input int i);
        return hangArr[i] ? (TIMEOUT + 2) : (staleArr[i] + latArr[i] + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Adder model and kick checker: checks launched operands, then plays done/result per op.
    initial begin : adderProc
        logic [31:0] a, b;
        int cnt, hold;
        bit hung;
        a = '0; b = '0; cnt = 0; hold = 0; hung = 1'b0;
        fpu_done = 1'b0;
        fpu_result = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                fpu_done = 1'b0;
                cnt      = 0;
                hold     = 0;
                kickIdx  = pushIdx;
                prevKick = 1'b0;
            end else begin
                if (fpu_kick) begin
                    checkOutput("kick_pulse", {31'd0, prevKick}, 32'd0);
                    checkOutput("kick_valid", {31'd0, fpu_valid}, 32'd1);
                    if (kickIdx >= pushIdx) begin
                        checkOutput("kick_unexpected", kickIdx, pushIdx);
                    end else begin
                        checkOutput("kick_op1", fpu_op1, expOp1[kickIdx]);
                        checkOutput("kick_op2", fpu_op2, expOp2[kickIdx]);
                        kickCycle[kickIdx] = cyc;
                        cnt  = latArr[kickIdx];
                        hold = staleArr[kickIdx];
                        hung = hangArr[kickIdx];
                        kickIdx++;
                    end
                    a = fpu_op1;
                    b = fpu_op2;
                    if (hold == 0) fpu_done = 1'b0;
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) fpu_done = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !hung) begin
                        fpu_done   = 1'b1;
                        fpu_result = adderModel(a, b);
                    end
                end
                prevKick = fpu_kick;
            end
        end
    end

    // Writeback monitor: checks latency on the first WB cycle and tag/data on each handshake.
    initial begin : wbMonitor
        forever begin
            @(negedge clk);
            if (reset) begin
                wbIdx  = pushIdx;
                wbSeen = 1'b0;
            end else if (wb_valid) begin
                if (wbIdx >= kickIdx) begin
                    checkOutput("wb_unexpected", wbIdx, kickIdx);
                end else begin
                    if (!wbSeen) begin
                        wbSeen = 1'b1;
                        checkOutput("wb_latency", cyc - kickCycle[wbIdx], expLat(wbIdx));
                        checkOutput("wb_fpu_valid", {31'd0, fpu_valid}, 32'd0);
                    end
                    if (wb_ready) begin
                        checkOutput("wb_tag", {27'd0, wb_tag}, {27'd0, expTag[wbIdx]});
                        checkOutput("wb_data", wb_data, expData(wbIdx));
                        wbIdx++;
                        wbSeen = 1'b0;
                    end
                end
            end
        end
    end

    // Writeback-ready driver: either a fixed level or random backpressure.
    initial begin : readyDriver
        wb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wb_ready = wbRand ? 1'($urandom_range(0, 1)) : wbHold;
        end
    end

    // Offer one op to the dispatcher and record what the scoreboard should see for it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                 input logic [TAG_W-1:0] tag, input int lat, input int stale,
                                 input bit hang);
        int guard;
        guard = 0;
        while (!in_ready && guard < 300) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            checkOutput("push_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            expOp1[pushIdx]   = a;
            expOp2[pushIdx]   = sub ? (b ^ 32'h8000_0000) : b;
            expTag[pushIdx]   = tag;
            latArr[pushIdx]   = lat;
            staleArr[pushIdx] = stale;
            hangArr[pushIdx]  = hang;
            pushIdx++;
            in_valid = 1'b1;
            in_op1   = a;
            in_op2   = b;
            in_sub   = sub;
            in_tag   = tag;
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input int maxCyc);
        int n;
        n = 0;
        while ((wbIdx != pushIdx || busy) && n < maxCyc) begin
            tick();
            n++;
        end
        checkOutput("drain", wbIdx, pushIdx);
        checkOutput("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("rst_kick", {31'd0, fpu_kick}, 32'd0);
        checkOutput("rst_fpu_valid", {31'd0, fpu_valid}, 32'd0);
        checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_tag", {27'd0, wb_tag}, 32'd0);
        checkOutput("rst_fpu_op1", fpu_op1, 32'd0);
        checkOutput("rst_fpu_op2", fpu_op2, 32'd0);
    endtask

    // Hard stop in case the stimulus itself gets stuck.
    initial begin : globalGuard
        #1_000_000;
        $display("[TB] FAIL global_timeout got=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin : mainSeq
        logic [31:0] ra, rb;
        int idx;
        in_valid = 1'b0;
        in_op1   = '0;
        in_op2   = '0;
        in_sub   = 1'b0;
        in_tag   = '0;
        reset    = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checkResetState();

        $display("[TB] single add");
        applyStimulus(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd3, 6, 0, 1'b0);
        checkOutput("t1_kick_early", {31'd0, fpu_kick}, 32'd0);
        tick();
        checkOutput("t1_kick", {31'd0, fpu_kick}, 32'd1);
        waitDrain(100);
        checkOutput("t1_kick_count", kickIdx, 32'd1);

        $display("[TB] subtract");
        applyStimulus(32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd7, 4, 0, 1'b0);
        tick();
        checkOutput("t2_fpu_op2", fpu_op2, 32'hBF80_0000);
        waitDrain(100);

        $display("[TB] fill with stalled adder");
        for (int i = 0; i < 5; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 5'(10 + i),
                          (i == 0) ? 40 : 3, 0, 1'b0);
        end
        checkOutput("t3_full_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("t3_busy", {31'd0, busy}, 32'd1);
        applyStimulus($urandom, $urandom, 1'b0, 5'd15, 3, 0, 1'b0);
        waitDrain(400);

        $display("[TB] stale done");
        applyStimulus($urandom, $urandom, 1'b0, 5'd20, 3, 0, 1'b0);
        applyStimulus($urandom, $urandom, 1'b1, 5'd21, 2, 3, 1'b0);
        waitDrain(100);

        $display("[TB] completion on watchdog expiry cycle");
        applyStimulus($urandom, $urandom, 1'b0, 5'd22, TIMEOUT + 1, 0, 1'b0);
        waitDrain(200);
        checkOutput("tie_timeout_err", {31'd0, timeout_err}, 32'd0);

        $display("[TB] hung adder");
        applyStimulus($urandom, $urandom, 1'b0, 5'd23, 5, 0, 1'b1);
        applyStimulus($urandom, $urandom, 1'b1, 5'd24, 4, 0, 1'b0);
        waitDrain(300);
        checkOutput("t5_timeout_err", {31'd0, timeout_err}, 32'd1);

        $display("[TB] random ops with backpressure");
        wbRand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom),
                          $urandom_range(2, 10), $urandom_range(0, 2), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        waitDrain(2000);
        wbRand = 1'b0;
        wbHold = 1'b1;
        tick();

        $display("[TB] writeback hold");
        wbHold = 1'b0;
        ra = $urandom;
        rb = $urandom;
        applyStimulus(ra, rb, 1'b0, 5'd25, 3, 0, 1'b0);
        idx = pushIdx - 1;
        for (int n = 0; n < 50 && !wb_valid; n++) tick();
        checkOutput("t6_wb_arrive", {31'd0, wb_valid}, 32'd1);
        for (int n = 0; n < 10; n++) begin
            checkOutput("t6_hold_valid", {31'd0, wb_valid}, 32'd1);
            checkOutput("t6_hold_tag", {27'd0, wb_tag}, 32'd25);
            checkOutput("t6_hold_data", wb_data, adderModel(ra, rb));
            tick();
        end
        checkOutput("t6_hold_idx", wbIdx, idx);
        wbHold = 1'b1;
        waitDrain(50);

        $display("[TB] reset while waiting");
        applyStimulus($urandom, $urandom, 1'b0, 5'd26, 50, 0, 1'b0);
        repeat (6) tick();
        checkOutput("t6_in_wait_valid", {31'd0, fpu_valid}, 32'd1);
        checkOutput("t6_in_wait_wb", {31'd0, wb_valid}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkResetState();
        applyStimulus(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd27, 3, 0, 1'b0);
        waitDrain(100);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
